// File: rtl/x_input_feeder.sv
// -----------------------------------------------------------------------------
// x_input_feeder
// Buffers host bytes in a FIFO. When a full frame is buffered it pulses
// start_in to the controller, then streams the frame onto X_load/valid_input
// while input_load_en is high. Each frame ends when xload_done arrives.
//
// Ports
//   clk, rst            system clock, asynchronous active-low reset
//   host_data/valid     host byte and its strobe
//   host_ready          FIFO has room (registered)
//   input_load_en       controller permits streaming
//   xload_done          loader has stored the frame (1-cycle pulse)
//   start_in            1-cycle pulse: a frame is ready
//   X_load/valid_input  streamed byte and its strobe (registered)
//   busy                state machine is not idle
//   frame_err           sticky: xload_done arrived before the frame was sent
//
// State    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for a full frame in the FIFO
// START    | frame buffered, start_in is driven on the next cycle
// WAIT_EN  | waiting for the controller to enable streaming
// STREAM   | popping one byte per enabled cycle
// DONE     | all bytes sent, waiting for xload_done
// FLUSH    | early xload_done: discarding the frame's unsent bytes
// -----------------------------------------------------------------------------
module x_input_feeder #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              input_load_en,
    input  logic              xload_done,
    output logic              start_in,
    output logic [DATA_W-1:0] X_load,
    output logic              valid_input,
    output logic              busy,
    output logic              frame_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REM_W = $clog2(FRAME_LEN + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FRAME_C   = CNT_W'(FRAME_LEN);
    localparam logic [REM_W-1:0] REM_FULL  = REM_W'(FRAME_LEN);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_START   = 3'd1;
    localparam logic [2:0] S_WAIT_EN = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_FLUSH   = 3'd5;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [REM_W-1:0]  r_remain;
    logic [2:0]        r_state;
    logic              r_host_ready;
    logic              r_start_in;
    logic [DATA_W-1:0] r_x_load;
    logic              r_valid;
    logic              r_frame_err;

    logic              w_push;
    logic              w_pop;
    logic              w_stream_pop;
    logic              w_early;
    logic [CNT_W-1:0]  w_count_next;
    logic [2:0]        w_state_next;

    assign w_push       = host_valid && r_host_ready;
    // Early done wins over a pop in the same cycle; that byte is flushed instead.
    assign w_early      = (r_state == S_STREAM) && xload_done;
    assign w_stream_pop = (r_state == S_STREAM) && input_load_en && !xload_done
                          && (r_remain != '0);
    assign w_pop        = w_stream_pop || ((r_state == S_FLUSH) && (r_remain != '0));

    always_comb begin
        w_count_next = r_count;
        if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (r_count >= FRAME_C) w_state_next = S_START;
            S_START:   w_state_next = S_WAIT_EN;
            S_WAIT_EN: if (input_load_en) w_state_next = S_STREAM;
            S_STREAM: begin
                if (w_early) begin
                    w_state_next = S_FLUSH;
                end else if (w_stream_pop && (r_remain == REM_W'(1))) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:    if (xload_done) w_state_next = S_IDLE;
            S_FLUSH:   if (r_remain <= REM_W'(1)) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Storage carries no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_remain     <= '0;
            r_state      <= S_IDLE;
            r_host_ready <= 1'b0;
            r_start_in   <= 1'b0;
            r_x_load     <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            // Registered from the next count so a full FIFO never sees a push.
            r_host_ready <= (w_count_next < DEPTH_C);
            r_start_in   <= (r_state == S_START);
            r_valid      <= w_stream_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_remain <= r_remain - REM_W'(1);
            end else if (r_state == S_START) begin
                r_remain <= REM_FULL;
            end
            if (w_stream_pop) begin
                r_x_load <= r_mem[r_rd_ptr];
            end
            if (w_early) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    assign host_ready  = r_host_ready;
    assign start_in    = r_start_in;
    assign X_load      = r_x_load;
    assign valid_input = r_valid;
    assign busy        = (r_state != S_IDLE);
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_x_input_feeder.sv
// -----------------------------------------------------------------------------
// tb_x_input_feeder
// Directed bench: each task drives one scenario and checks its own results.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_x_input_feeder;

    logic       clk;
    logic       rst;
    logic [7:0] host_data;
    logic       host_valid;
    logic       host_ready;
    logic       input_load_en;
    logic       xload_done;
    logic       start_in;
    logic [7:0] X_load;
    logic       valid_input;
    logic       busy;
    logic       frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] got_bytes [32];

    x_input_feeder #(.DATA_W(8), .FIFO_DEPTH(16), .FRAME_LEN(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .input_load_en (input_load_en),
        .xload_done    (xload_done),
        .start_in      (start_in),
        .X_load        (X_load),
        .valid_input   (valid_input),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Push n consecutive bytes starting at value first; counts start pulses seen.
    task automatic push_bytes(input int first, input int n, output int starts);
        starts = 0;
        for (int i = 0; i < n; i++) begin
            host_data  = 8'(first + i);
            host_valid = 1'b1;
            @(negedge clk);
            if (start_in) starts++;
        end
        host_valid = 1'b0;
    endtask

    // Record streamed bytes until n_want are seen or max_cyc cycles pass.
    // Optionally drops input_load_en for pause_len cycles after byte pause_after.
    task automatic collect(input int max_cyc, input int n_want, input int pause_after,
                           input int pause_len, output int got, output int gaps,
                           output int starts, output int cyc);
        int pause_left;
        got = 0; gaps = 0; starts = 0; cyc = 0; pause_left = 0;
        for (int i = 0; i < 32; i++) got_bytes[i] = 8'h00;
        while (got < n_want && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (start_in) starts++;
            if (pause_left > 0) begin
                pause_left--;
                if (pause_left == 0) input_load_en = 1'b1;
            end
            if (valid_input) begin
                if (got < 32) got_bytes[got] = X_load;
                got++;
                if (got == pause_after) begin
                    input_load_en = 1'b0;
                    pause_left    = pause_len;
                end
            end else if (got > 0) begin
                gaps++;
            end
        end
    endtask

    task automatic done_pulse();
        xload_done = 1'b1;
        @(negedge clk);
        xload_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; host_data = 8'h00; host_valid = 1'b0;
        input_load_en = 1'b0; xload_done = 1'b0;
        #3;
        n_tests++;
        if ({start_in, X_load, valid_input, busy, frame_err, host_ready} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {start_in, X_load, valid_input, busy, frame_err, host_ready});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", host_ready);
        end
    endtask

    task automatic test_basic();
        int s, got, gaps, st, cyc;
        input_load_en = 1'b1;
        push_bytes(1, 8, s);
        n_tests++;
        if (start_in !== 1'b0 || s != 0) begin
            n_fail++;
            $display("FAIL basic_start_early: start_in=%b pulses=%0d expected 0", start_in, s);
        end
        @(negedge clk);
        n_tests++;
        if (start_in !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start_p1: start_in=%b busy=%b expected 0/1", start_in, busy);
        end
        @(negedge clk);
        n_tests++;
        if (start_in !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start_p2: start_in=%b expected 1", start_in);
        end
        @(negedge clk);
        n_tests++;
        if (start_in !== 1'b0 || valid_input !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start_p3: start_in=%b valid=%b expected 0/0", start_in, valid_input);
        end
        @(negedge clk);
        n_tests++;
        if (valid_input !== 1'b1 || X_load !== 8'h01) begin
            n_fail++;
            $display("FAIL basic_first_byte: valid=%b X_load=%h expected 1/01", valid_input, X_load);
        end
        collect(20, 7, -1, 0, got, gaps, st, cyc);
        n_tests++;
        if (got != 7 || cyc != 7 || st != 0) begin
            n_fail++;
            $display("FAIL basic_stream: got=%0d cycles=%0d starts=%0d expected 7/7/0", got, cyc, st);
        end
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (got_bytes[i] !== 8'(i + 2)) begin
                n_fail++;
                $display("FAIL basic_byte%0d: got %h expected %h", i + 2, got_bytes[i], 8'(i + 2));
            end
        end
        done_pulse();
        n_tests++;
        if (busy !== 1'b0 || valid_input !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done: busy=%b valid=%b expected 0/0", busy, valid_input);
        end
    endtask

    task automatic test_pause();
        int s, got, gaps, st, cyc;
        input_load_en = 1'b1;
        push_bytes(1, 8, s);
        collect(60, 8, 3, 3, got, gaps, st, cyc);
        n_tests++;
        if (got != 8 || gaps != 3 || (st + s) != 1) begin
            n_fail++;
            $display("FAIL pause_stream: got=%0d gaps=%0d starts=%0d expected 8/3/1", got, gaps, st + s);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got_bytes[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL pause_byte%0d: got %h expected %h", i + 1, got_bytes[i], 8'(i + 1));
            end
        end
        done_pulse();
    endtask

    task automatic test_full();
        int s, got, gaps, st, cyc;
        input_load_en = 1'b0;
        push_bytes(1, 16, s);
        n_tests++;
        if (host_ready !== 1'b0 || s != 1) begin
            n_fail++;
            $display("FAIL full_ready: ready=%b starts=%0d expected 0/1", host_ready, s);
        end
        push_bytes(8'hAA, 1, s);
        n_tests++;
        if (host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_refused: ready=%b expected 0", host_ready);
        end
        input_load_en = 1'b1;
        collect(40, 8, -1, 0, got, gaps, st, cyc);
        n_tests++;
        if (got != 8 || st != 0) begin
            n_fail++;
            $display("FAIL full_frame1: got=%0d starts=%0d expected 8/0", got, st);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got_bytes[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL full_f1_byte%0d: got %h expected %h", i + 1, got_bytes[i], 8'(i + 1));
            end
        end
        done_pulse();
        collect(40, 8, -1, 0, got, gaps, st, cyc);
        n_tests++;
        if (got != 8 || st != 1) begin
            n_fail++;
            $display("FAIL full_frame2: got=%0d starts=%0d expected 8/1", got, st);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got_bytes[i] !== 8'(i + 9)) begin
                n_fail++;
                $display("FAIL full_f2_byte%0d: got %h expected %h", i + 9, got_bytes[i], 8'(i + 9));
            end
        end
        done_pulse();
        n_tests++;
        if (busy !== 1'b0 || host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_end: busy=%b ready=%b expected 0/1", busy, host_ready);
        end
    endtask

    task automatic test_short();
        int s, got, gaps, st, cyc;
        bit bad;
        input_load_en = 1'b1;
        push_bytes(8'h21, 7, s);
        bad = (s != 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (start_in || busy) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL short_idle: start_in or busy seen with 7 bytes, expected none");
        end
        push_bytes(8'h28, 1, s);
        collect(40, 8, -1, 0, got, gaps, st, cyc);
        n_tests++;
        if (got != 8 || (st + s) != 1) begin
            n_fail++;
            $display("FAIL short_frame: got=%0d starts=%0d expected 8/1", got, st + s);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got_bytes[i] !== 8'(8'h21 + i)) begin
                n_fail++;
                $display("FAIL short_byte%0d: got %h expected %h", i, got_bytes[i], 8'(8'h21 + i));
            end
        end
        done_pulse();
    endtask

    task automatic test_early();
        int s, got, gaps, st, cyc;
        input_load_en = 1'b0;
        push_bytes(8'h31, 16, s);
        input_load_en = 1'b1;
        collect(40, 4, -1, 0, got, gaps, st, cyc);
        xload_done = 1'b1;
        @(negedge clk);
        xload_done = 1'b0;
        n_tests++;
        if (got != 4 || frame_err !== 1'b1 || valid_input !== 1'b0) begin
            n_fail++;
            $display("FAIL early_err: got=%0d frame_err=%b valid=%b expected 4/1/0",
                     got, frame_err, valid_input);
        end
        collect(60, 8, -1, 0, got, gaps, st, cyc);
        n_tests++;
        if (got != 8 || st != 1) begin
            n_fail++;
            $display("FAIL early_next: got=%0d starts=%0d expected 8/1", got, st);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got_bytes[i] !== 8'(8'h39 + i)) begin
                n_fail++;
                $display("FAIL early_byte%0d: got %h expected %h", i, got_bytes[i], 8'(8'h39 + i));
            end
        end
        done_pulse();
        n_tests++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sticky: frame_err=%b busy=%b expected 1/0", frame_err, busy);
        end
    endtask

    task automatic test_reset_mid();
        int s, got, gaps, st, cyc;
        input_load_en = 1'b0;
        push_bytes(8'h51, 8, s);
        input_load_en = 1'b1;
        collect(40, 3, -1, 0, got, gaps, st, cyc);
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({start_in, X_load, valid_input, busy, frame_err, host_ready} !== 13'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b expected all zero",
                     {start_in, X_load, valid_input, busy, frame_err, host_ready});
        end
        input_load_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_bytes(8'h61, 8, s);
        input_load_en = 1'b1;
        collect(40, 8, -1, 0, got, gaps, st, cyc);
        n_tests++;
        if (got != 8 || (st + s) != 1 || gaps != 0) begin
            n_fail++;
            $display("FAIL midreset_frame: got=%0d starts=%0d gaps=%0d expected 8/1/0",
                     got, st + s, gaps);
        end
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (got_bytes[i] !== 8'(8'h61 + i)) begin
                n_fail++;
                $display("FAIL midreset_byte%0d: got %h expected %h", i, got_bytes[i], 8'(8'h61 + i));
            end
        end
        done_pulse();
        n_tests++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_end: busy=%b frame_err=%b expected 0/0", busy, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_full();
        test_short();
        test_early();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/x_input_feeder.md
Name: x_input_feeder

Overview:
Upstream stage of the accelerator core. It accepts bytes from the host on a valid/ready handshake and buffers them in an internal FIFO. Once a full frame is buffered, it pulses start_in to the controller, then streams the frame onto X_load/valid_input while the controller asserts input_load_en. It finishes each frame by waiting for xload_done.

Parameters:
DATA_W, 8, width of a host byte and of X_load
FIFO_DEPTH, 16, FIFO entries; power of two, must be >= FRAME_LEN
FRAME_LEN, 8, bytes per frame delivered to the loader

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
host_data  input  DATA_W  host byte
host_valid  input  1  host byte present
host_ready  output  1  FIFO can accept; high when count < FIFO_DEPTH
input_load_en  input  1  controller permits streaming
xload_done  input  1  loader reports frame stored (1-cycle pulse)
start_in  output  1  1-cycle pulse to controller: frame ready
X_load  output  DATA_W  byte to loader, registered
valid_input  output  1  X_load valid this cycle, registered
busy  output  1  high in any state except IDLE
frame_err  output  1  sticky: xload_done arrived before frame fully sent

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO pointers and count = 0; state = IDLE.
  - All outputs = 0, except host_ready = 1 one cycle after reset release.
  - Reset mid-frame discards all buffered data; no partial resume.
- FIFO:
  - Push when host_valid && host_ready.
  - Pop only in STREAM. Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
  - Push while full is impossible (host_ready=0). No overwrite.
- State machine (registered outputs):
  - IDLE: when count >= FRAME_LEN, go to START.
  - START: assert start_in for exactly one cycle, then go to WAIT_EN.
  - WAIT_EN: when input_load_en=1, go to STREAM.
  - STREAM:
    - Each cycle with input_load_en=1 and sent < FRAME_LEN: pop one byte. Next cycle, X_load = that byte and valid_input = 1.
    - When input_load_en=0, valid_input = 0 next cycle and X_load holds its last value. Resume when input_load_en returns; no byte is lost or duplicated.
    - After the FRAME_LEN-th pop, go to DONE.
  - DONE: valid_input = 0. When xload_done=1, go to IDLE.
- Latency:
  - start_in rises 2 cycles after the push that makes count reach FRAME_LEN (IDLE detects, START drives).
  - First valid_input appears 2 cycles after input_load_en is first seen high in WAIT_EN.
- xload_done in STREAM before all bytes are sent (early done):
  - set frame_err;
  - discard the frame's unsent bytes from the FIFO, at most one pop per cycle in a flush sub-state; valid_input stays 0;
  - then go to IDLE.
  - frame_err clears only on reset.
- xload_done in IDLE, START or WAIT_EN is ignored.
- Back-to-back frames: if count >= FRAME_LEN on entering IDLE, START follows on the next cycle.
- Host pushes continue in every state, including during streaming.

Test Plan:
- Reset, then push 8 bytes 0x01..0x08 (one per cycle) -> start_in single pulse 2 cycles after 8th push. With input_load_en held high: X_load = 0x01..0x08 on 8 consecutive valid_input cycles. xload_done -> busy=0.
- Same frame, input_load_en low for 3 cycles after the 3rd byte -> valid_input low for exactly 3 cycles; sequence 0x01..0x08 intact, no repeat or skip.
- Push 16 bytes with input_load_en=0 -> host_ready=0 at count 16. Push attempt on byte 17 is refused. After the first frame streams, the second frame 0x09..0x10 streams after one more start_in pulse.
- Push 7 bytes only -> start_in never asserts and busy stays 0. 8th byte -> start_in pulses.
- xload_done after the 4th streamed byte -> frame_err=1; bytes 5..8 discarded; next frame starts with the 9th pushed byte.
- Assert rst=0 mid-STREAM -> all outputs 0 immediately. After release, a fresh 8-byte push produces a normal frame.
